// File: rtl/shifter.sv
// Serial/parallel shift register with a bidirectional parallel bus.
// Optional SHIFTER_DIR_EN adds a dir input selecting right shift (dir=1).
module shifter #(
    parameter int Len = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           wr,
    input  logic           rd,
    input  logic           si,
`ifdef SHIFTER_DIR_EN
    input  logic           dir,
`endif
    output logic           so,
    inout  wire  [Len-1:0] data_io
);

    logic [Len-1:0] r_shift_reg;
    logic [Len-1:0] w_shift_next;
    logic           w_drive;
    logic           w_so;

    // Next value for a shift; direction is fixed left unless dir support is built in
    always_comb begin
        w_shift_next = r_shift_reg;
        w_so         = 1'b0;
`ifdef SHIFTER_DIR_EN
        if (dir == 1'b1) begin
            w_shift_next = {si, r_shift_reg[Len-1:1]};
            w_so         = r_shift_reg[0];
        end else begin
            w_shift_next = {r_shift_reg[Len-2:0], si};
            w_so         = r_shift_reg[Len-1];
        end
`else
        w_shift_next = {r_shift_reg[Len-2:0], si};
        w_so         = r_shift_reg[Len-1];
`endif
    end

    // State update: reset beats load, load beats shift, otherwise hold
    always_ff @(posedge clk) begin
        if (rst == 1'b1) begin
            r_shift_reg <= {Len{1'b0}};
        end else if (wr == 1'b0) begin
            r_shift_reg <= data_io;
        end else if (en == 1'b0) begin
            r_shift_reg <= w_shift_next;
        end else begin
            r_shift_reg <= r_shift_reg;
        end
    end

    // A write strobe always suppresses driving, so a simultaneous rd/wr loads
    // from the bus instead of fighting it.
    assign w_drive = (rd == 1'b0) && (wr == 1'b1);
    assign data_io = w_drive ? r_shift_reg : {Len{1'bz}};
    assign so      = w_so;

endmodule

// File: tb/tb_shifter.sv
// Directed scoreboard bench for shifter: expected values are queued as the
// stimulus is applied and compared against so / data_io as they are observed.
module tb_shifter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       wr;
    logic       rd;
    logic       si;
`ifdef SHIFTER_DIR_EN
    logic       dir;
`endif
    logic       so;
    wire  [7:0] data_io;

    logic       r_tb_oe;
    logic [7:0] r_tb_val;
    logic [7:0] exp_reg;

    int checks;
    int errors;

    logic [7:0] q_exp[$];
    string      q_tag[$];

    assign data_io = r_tb_oe ? r_tb_val : 8'bzzzz_zzzz;

    shifter #(.Len(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .wr      (wr),
        .rd      (rd),
        .si      (si),
`ifdef SHIFTER_DIR_EN
        .dir     (dir),
`endif
        .so      (so),
        .data_io (data_io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [7:0] val);
        q_tag.push_back(tag);
        q_exp.push_back(val);
    endtask

    task automatic check_next(input logic [7:0] obs);
        string      tag;
        logic [7:0] expv;
        if (q_exp.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: observed %h expected none", obs);
        end else begin
            tag  = q_tag.pop_front();
            expv = q_exp.pop_front();
            checks++;
            assert (obs === expv) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, expv);
            end
        end
    endtask

    // Read shift_reg through the bus in the current cycle, then release
    task automatic peek(input string tag, input logic [7:0] val);
        push_exp(tag, val);
        wr = 1'b1;
        rd = 1'b0;
        #1;
        check_next(data_io);
        rd = 1'b1;
        #1;
    endtask

    task automatic check_so(input string tag, input logic val);
        push_exp(tag, {7'd0, val});
        check_next({7'd0, so});
    endtask

    // With rd=1 the block must not drive: bench drives 8'h00 and must read it back
    task automatic check_released(input string tag);
        push_exp(tag, 8'h00);
        r_tb_val = 8'h00;
        r_tb_oe  = 1'b1;
        #1;
        check_next(data_io);
        r_tb_oe  = 1'b0;
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        en       = 1'b1;
        wr       = 1'b1;
        rd       = 1'b1;
        si       = 1'b0;
`ifdef SHIFTER_DIR_EN
        dir      = 1'b0;
`endif
        r_tb_oe  = 1'b0;
        r_tb_val = 8'h00;

        // Reset
        tick();
        rst = 1'b0;
        exp_reg = 8'h00;
        check_so("reset_so", 1'b0);
        peek("reset_reg", exp_reg);

        // Shift in 0,1,1,0 from zero
        en = 1'b0;
        si = 1'b0; tick(); exp_reg = {exp_reg[6:0], 1'b0};
        si = 1'b1; tick(); exp_reg = {exp_reg[6:0], 1'b1};
        si = 1'b1; tick(); exp_reg = {exp_reg[6:0], 1'b1};
        si = 1'b0; tick(); exp_reg = {exp_reg[6:0], 1'b0};
        en = 1'b1;
        push_exp("shift_model", 8'h06);
        check_next(exp_reg);
        peek("shift_0110", exp_reg);
        check_so("shift_so", exp_reg[7]);
        si = 1'b1;
        tick();
        tick();
        peek("hold_reg", exp_reg);
        check_released("release_after_rd");

        // Load with rd and wr both low: write wins, bus not driven by block
        r_tb_val = 8'hA5;
        r_tb_oe  = 1'b1;
        wr = 1'b0;
        rd = 1'b0;
        #1;
        push_exp("rdwr_bus_undriven", 8'hA5);
        check_next(data_io);
        tick();
        exp_reg = 8'hA5;
        wr = 1'b1;
        rd = 1'b1;
        r_tb_oe = 1'b0;
        #1;
        check_so("load_so", exp_reg[7]);
        peek("load_A5", exp_reg);

        // Load beats shift
        r_tb_val = 8'h3C;
        r_tb_oe  = 1'b1;
        wr = 1'b0;
        en = 1'b0;
        si = 1'b1;
        tick();
        exp_reg = 8'h3C;
        wr = 1'b1;
        r_tb_oe = 1'b0;
        peek("load_over_shift", exp_reg);
        check_so("load_over_shift_so", exp_reg[7]);

        // Continue shifting, then reset mid-shift
        tick();
        exp_reg = {exp_reg[6:0], 1'b1};
        peek("shift_after_load", exp_reg);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_reg = 8'h00;
        en = 1'b1;
        peek("reset_mid_shift", exp_reg);
        check_so("reset_mid_shift_so", 1'b0);

        // MSB boundary: a single 1 walks to so after 8 shifts
        en = 1'b0;
        si = 1'b1;
        tick();
        exp_reg = {exp_reg[6:0], 1'b1};
        si = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_reg = {exp_reg[6:0], 1'b0};
        end
        check_so("walk_so_before_msb", 1'b0);
        tick();
        exp_reg = {exp_reg[6:0], 1'b0};
        check_so("walk_so_at_msb", 1'b1);
        en = 1'b1;
        peek("walk_reg", 8'h80);
        check_released("release_walk");
        en = 1'b0;
        tick();
        exp_reg = {exp_reg[6:0], 1'b0};
        en = 1'b1;
        check_so("walk_so_after_msb", 1'b0);
        peek("walk_out", exp_reg);

`ifdef SHIFTER_DIR_EN
        // Right shift
        dir = 1'b1;
        r_tb_val = 8'h81;
        r_tb_oe  = 1'b1;
        wr = 1'b0;
        tick();
        wr = 1'b1;
        r_tb_oe = 1'b0;
        check_so("dir_load_so", 1'b1);
        en = 1'b0;
        si = 1'b0;
        tick();
        en = 1'b1;
        peek("dir_right_40", 8'h40);
        check_so("dir_right_so", 1'b0);
`endif

        if (q_exp.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover: observed %0d expected 0", q_exp.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
